// File: rtl/vga_scan_timing.sv
// 640x480@60 VGA scan generator: pixel/line counters, active-low syncs, frame strobe,
// a frame-rate flash square wave and a sticky start-up-delay flag for the renderers.
module vga_scan_timing #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int FLASH_FRAMES = 15,
    parameter int START_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    output logic [9:0] hOutQ,
    output logic [9:0] vOutQ,
    output logic       Hsync,
    output logic       Vsync,
    output logic       activeVideo,
    output logic       frame,
    output logic       syncFlash,
    output logic       doneCount
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Flash counter only has to reach FLASH_FRAMES-1; keep at least one bit.
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [7:0]    START_CNT  = 8'(START_FRAMES);

    logic [FW-1:0] flash_cnt;
    logic [7:0]    start_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hOutQ <= '0;
            vOutQ <= '0;
        end else if (hOutQ == H_LAST) begin
            hOutQ <= '0;
            vOutQ <= (vOutQ == V_LAST) ? '0 : vOutQ + 10'd1;
        end else begin
            hOutQ <= hOutQ + 10'd1;
        end
    end

    // Decodes of the registered counters only, so they line up with hOutQ/vOutQ.
    assign Hsync       = !((hOutQ >= HS_START) && (hOutQ < HS_END));
    assign Vsync       = !((vOutQ >= VS_START) && (vOutQ < VS_END));
    assign activeVideo = (hOutQ < H_VIS) && (vOutQ < V_VIS);
    assign frame       = (hOutQ == H_LAST) && (vOutQ == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt <= '0;
            syncFlash <= 1'b0;
        end else if (frame) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt <= '0;
                syncFlash <= ~syncFlash;
            end else begin
                flash_cnt <= flash_cnt + FW'(1);
            end
        end
    end

    // restart wins over a coincident frame; once done, the counter parks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_cnt <= '0;
            doneCount <= 1'b0;
        end else if (restart) begin
            start_cnt <= '0;
            doneCount <= 1'b0;
        end else if (frame && !doneCount) begin
            start_cnt <= start_cnt + 8'd1;
            if (start_cnt + 8'd1 == START_CNT) begin
                doneCount <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Randomized bench for vga_scan_timing with shrunken timing so many frames fit in a short run;
// expected outputs come from arithmetic on elapsed cycles and frame counts since reset/restart.
module tb_vga_scan_timing;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 10, VF = 1, VS = 2, VB = 2;
    localparam int FF = 2, SF = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int N_CYCLES = 15000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] hOutQ, vOutQ;
    logic       Hsync, Vsync, activeVideo, frame, syncFlash, doneCount;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset release, frame strobes since reset,
    // frame strobes since the last restart.
    int  t = 0;
    int  frames = 0;
    int  arm = 0;
    bit  frame_now = 1'b0;
    bit  did_restart = 1'b0;
    bit  did_reset = 1'b0;

    vga_scan_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FLASH_FRAMES(FF), .START_FRAMES(SF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .restart(restart),
        .hOutQ(hOutQ),
        .vOutQ(vOutQ),
        .Hsync(Hsync),
        .Vsync(Vsync),
        .activeVideo(activeVideo),
        .frame(frame),
        .syncFlash(syncFlash),
        .doneCount(doneCount)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    task automatic check_reset_values(input string ctx);
        check_eq({ctx, "_h"},      int'(hOutQ), 0);
        check_eq({ctx, "_v"},      int'(vOutQ), 0);
        check_eq({ctx, "_hsync"},  int'(Hsync), 1);
        check_eq({ctx, "_vsync"},  int'(Vsync), 1);
        check_eq({ctx, "_active"}, int'(activeVideo), 1);
        check_eq({ctx, "_frame"},  int'(frame), 0);
        check_eq({ctx, "_flash"},  int'(syncFlash), 0);
        check_eq({ctx, "_done"},   int'(doneCount), 0);
    endtask

    task automatic check_model();
        int h, v;
        h = t % HT;
        v = (t / HT) % VT;
        check_eq("hOutQ",       int'(hOutQ), h);
        check_eq("vOutQ",       int'(vOutQ), v);
        check_eq("Hsync",       int'(Hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
        check_eq("Vsync",       int'(Vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
        check_eq("activeVideo", int'(activeVideo), (h < HA && v < VA) ? 1 : 0);
        check_eq("frame",       int'(frame), (h == HT - 1 && v == VT - 1) ? 1 : 0);
        check_eq("syncFlash",   int'(syncFlash), (frames / FF) % 2);
        check_eq("doneCount",   int'(doneCount), (arm >= SF) ? 1 : 0);
    endtask

    // Called just after a falling edge; drops reset between edges and checks it acts at once.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_values("rst_async");
        @(posedge clk);
        #1 check_reset_values("rst_held");
        @(negedge clk);
        #2 reset_n = 1'b1;
        t = 0;
        frames = 0;
        arm = 0;
    endtask

    initial begin
        int h, v;
        reset_n = 1'b0;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst_init");
        #2 reset_n = 1'b1;
        frame_now = 1'b0;

        for (int i = 0; i < N_CYCLES; i++) begin
            @(posedge clk);
            if (restart) arm = 0;
            else if (frame_now) arm++;
            if (frame_now) frames++;
            t++;

            @(negedge clk);
            check_model();
            h = t % HT;
            v = (t / HT) % VT;
            frame_now = (h == HT - 1) && (v == VT - 1);

            if (i >= 6000 && i < 6800) begin
                restart = 1'b1;
            end else begin
                restart = ($urandom_range(0, 699) == 0);
            end
            if (!did_restart && i > 2000 && frame_now && arm >= SF) begin
                restart = 1'b1;
                did_restart = 1'b1;
            end

            if ((!did_reset && i > 9000 && h == 12 && v == 7) ||
                (i > 500 && $urandom_range(0, 4999) == 0)) begin
                if (i > 9000) did_reset = 1'b1;
                restart = 1'b0;
                pulse_reset();
                frame_now = 1'b0;
            end
        end

        if (!did_restart) check_eq("directed_restart_reached", 0, 1);
        if (!did_reset) check_eq("directed_reset_reached", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
